// File: rtl/sr_cmd_debounce.sv
// -----------------------------------------------------------------------------
// sr_cmd_debounce
//
// Front end for the SR flip-flop. The raw set and reset request lines are
// synchronized, debounced and rising-edge detected, then arbitrated so the
// flip-flop only ever sees single-cycle s / r pulses that are never high
// together.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive synchronized cycles a new level must persist
//                    before the debounced level follows it (2..2**CNT_W)
//   CNT_W            width of each debounce counter
//   SET_WINS         same-cycle tie: 0 = reset command wins, 1 = set wins
//
// Ports:
//   clk          in   rising-edge system clock
//   rst          in   asynchronous active-low reset
//   set_in       in   raw set request (asynchronous, may bounce)
//   reset_in     in   raw reset request (asynchronous, may bounce)
//   s            out  one-cycle set command pulse
//   r            out  one-cycle reset command pulse
//   set_level    out  debounced level of set_in
//   reset_level  out  debounced level of reset_in
//   conflict     out  one-cycle flag: both rose together, loser dropped
// -----------------------------------------------------------------------------
module sr_cmd_debounce #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5,
    parameter bit SET_WINS        = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic set_in,
    input  logic reset_in,
    output logic s,
    output logic r,
    output logic set_level,
    output logic reset_level,
    output logic conflict
);

    // Terminal count: the level flips on the edge where the counter already
    // holds DEBOUNCE_CYCLES-1, so the counter never wraps.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Channel 0 = set, channel 1 = reset.
    logic [1:0]       raw;
    logic [1:0]       meta;
    logic [1:0]       sync;
    logic [1:0]       level;
    logic [1:0]       prev;
    logic [1:0]       rise;
    logic [CNT_W-1:0] cnt [2];

    assign raw  = {reset_in, set_in};
    assign rise = level & ~prev;

    assign set_level   = level[0];
    assign reset_level = level[1];

    // NOTE: every register in this block is updated with <= so all of them
    // sample the pre-edge values; a blocking assignment here would let the
    // synchronizer collapse into a single flop and skew the edge detector.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the counters are a handful of flops, not a memory, so they
            // are cleared with everything else to drop any partial count.
            meta     <= '0;
            sync     <= '0;
            level    <= '0;
            prev     <= '0;
            for (int ch = 0; ch < 2; ch++) begin
                cnt[ch] <= '0;
            end
            s        <= 1'b0;
            r        <= 1'b0;
            conflict <= 1'b0;
        end else begin
            meta <= raw;
            sync <= meta;
            prev <= level;

            for (int ch = 0; ch < 2; ch++) begin
                if (sync[ch] == level[ch]) begin
                    cnt[ch] <= '0;
                end else if (cnt[ch] == CNT_MAX) begin
                    level[ch] <= sync[ch];
                    cnt[ch]   <= '0;
                end else begin
                    cnt[ch] <= cnt[ch] + CNT_W'(1);
                end
            end

            // On a tie only the winner fires; the loser is discarded, not held.
            s        <= rise[0] & (~rise[1] |  SET_WINS);
            r        <= rise[1] & (~rise[0] | ~SET_WINS);
            conflict <= rise[0] & rise[1];
        end
    end

endmodule

// File: tb/tb_sr_cmd_debounce.sv
// -----------------------------------------------------------------------------
// tb_sr_cmd_debounce
//
// Two instances share the same inputs: dut0 with SET_WINS=0 and dut1 with
// SET_WINS=1. Stimulus pushes the expected pulse (cycle and s/r/conflict) into
// one queue per instance; a monitor per instance pops and compares whenever the
// instance shows any pulse.
// -----------------------------------------------------------------------------
module tb_sr_cmd_debounce;

    localparam int D   = 16;
    localparam int LAT = D + 3;

    typedef struct {
        int   cyc;
        logic s;
        logic r;
        logic c;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic set_in = 1'b0;
    logic reset_in = 1'b0;

    logic s0, r0, sl0, rl0, c0;
    logic s1, r1, sl1, rl1, c1;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t q0[$];
    exp_t q1[$];

    sr_cmd_debounce #(.DEBOUNCE_CYCLES(D), .CNT_W(5), .SET_WINS(1'b0)) dut0 (
        .clk(clk), .rst(rst), .set_in(set_in), .reset_in(reset_in),
        .s(s0), .r(r0), .set_level(sl0), .reset_level(rl0), .conflict(c0)
    );

    sr_cmd_debounce #(.DEBOUNCE_CYCLES(D), .CNT_W(5), .SET_WINS(1'b1)) dut1 (
        .clk(clk), .rst(rst), .set_in(set_in), .reset_in(reset_in),
        .s(s1), .r(r1), .set_level(sl1), .reset_level(rl1), .conflict(c1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_negs(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_both(input int c, input logic s, input logic r, input logic cf,
                             input logic s_b, input logic r_b, input logic cf_b);
        exp_t e;
        e.cyc = c; e.s = s;   e.r = r;   e.c = cf;   q0.push_back(e);
        e.cyc = c; e.s = s_b; e.r = r_b; e.c = cf_b; q1.push_back(e);
    endtask

    task automatic check_quiet(input string name);
        check({name, "_dut0"}, {s0, r0, c0, sl0, rl0}, 5'b0);
        check({name, "_dut1"}, {s1, r1, c1, sl1, rl1}, 5'b0);
    endtask

    // Monitors: any pulse on s, r or conflict must match the head of the queue.
    always @(negedge clk) begin
        if (s0 | r0 | c0) begin
            if (q0.size() == 0) begin
                check("dut0_unexpected_pulse", {29'd0, s0, r0, c0}, 32'd0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                check("dut0_pulse_cycle", cyc, e.cyc);
                check("dut0_pulse_src", {29'd0, s0, r0, c0}, {29'd0, e.s, e.r, e.c});
            end
        end
    end

    always @(negedge clk) begin
        if (s1 | r1 | c1) begin
            if (q1.size() == 0) begin
                check("dut1_unexpected_pulse", {29'd0, s1, r1, c1}, 32'd0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("dut1_pulse_cycle", cyc, e.cyc);
                check("dut1_pulse_src", {29'd0, s1, r1, c1}, {29'd0, e.s, e.r, e.c});
            end
        end
    end

    initial begin
        int base;

        // Reset then idle.
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wait_negs(1);
            check_quiet("in_reset");
        end
        rst = 1'b1;
        #1 check_quiet("after_release");
        wait_negs(50);
        check_quiet("idle");

        // Clean set press, held.
        set_in = 1'b1;
        base = cyc;
        push_both(base + LAT, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_negs(D + 1);
        check("set_level_edge17", {31'd0, sl0}, 32'd0);
        wait_negs(1);
        check("set_level_edge18", {31'd0, sl0}, 32'd1);
        wait_negs(40);
        check("set_level_held", {31'd0, sl1}, 32'd1);
        set_in = 1'b0;
        wait_negs(D + 4);
        check("set_level_fell", {31'd0, sl0}, 32'd0);

        // Bounce rejection: 5-cycle runs, then held high.
        for (int i = 0; i < 6; i++) begin
            set_in = 1'b1;
            wait_negs(5);
            set_in = 1'b0;
            wait_negs(5);
        end
        check("bounce_level", {31'd0, sl0}, 32'd0);
        set_in = 1'b1;
        base = cyc;
        push_both(base + LAT, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_negs(LAT + 10);
        set_in = 1'b0;
        wait_negs(D + 6);

        // Simultaneous press: dut0 reset wins, dut1 set wins.
        set_in = 1'b1;
        reset_in = 1'b1;
        base = cyc;
        push_both(base + LAT, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        wait_negs(LAT + 5);
        check("tie_levels", {30'd0, sl0, rl0}, 32'd3);
        set_in = 1'b0;
        reset_in = 1'b0;
        wait_negs(D + 6);
        check("tie_levels_fell", {30'd0, sl1, rl1}, 32'd0);

        // Staggered presses: reset 3 cycles after set.
        set_in = 1'b1;
        base = cyc;
        push_both(base + LAT, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        push_both(base + LAT + 3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_negs(3);
        reset_in = 1'b1;
        wait_negs(LAT + 5);
        set_in = 1'b0;
        reset_in = 1'b0;
        wait_negs(D + 6);

        // Reset mid-count: partial count is lost, fresh press after release.
        set_in = 1'b1;
        wait_negs(9);
        rst = 1'b0;
        #1 check_quiet("midcount_reset");
        wait_negs(2);
        check_quiet("midcount_reset_held");
        rst = 1'b1;
        base = cyc;
        push_both(base + LAT, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_negs(D + 1);
        check("midcount_level_edge17", {31'd0, sl0}, 32'd0);
        wait_negs(1);
        check("midcount_level_edge18", {31'd0, sl0}, 32'd1);
        wait_negs(20);
        set_in = 1'b0;
        wait_negs(D + 6);

        // Every expected pulse must have been seen.
        check("dut0_missing_pulses", q0.size(), 32'd0);
        check("dut1_missing_pulses", q1.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
